// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]         rd_data,
    output logic [NRD-1:0]              rd_busy,
    input  logic [NWR-1:0]              wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]         wr_data,
    input  logic                        iss_en,
    input  logic [$clog2(NREGS)-1:0]    iss_rd,
    output logic                        iss_ok,
    input  logic                        flush,
    output logic [$clog2(NREGS):0]      busy_cnt
);
    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic [AW:0]                busy_cnt_q, busy_cnt_d;

    assign iss_ok   = iss_en && (iss_rd == '0 || !busy_q[iss_rd]) && !flush;
    assign busy_cnt = busy_cnt_q;

    // Ports are walked in ascending order so the highest index lands last and wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_addr[p*AW +: AW] != '0) begin
                regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
                busy_d[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        // A new producer claims the register over a same-cycle writeback release.
        if (iss_ok && iss_rd != '0)
            busy_d[iss_rd] = 1'b1;
        if (flush)
            busy_d = '0;
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < NREGS; r++)
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;

        assign a = rd_addr[i*AW +: AW];

        always_comb begin
            d = regs_q[a];
            b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] == a) begin
                    d = wr_data[p*XLEN +: XLEN];
                    b = iss_ok && iss_rd == a;
                end
            end
`endif
            if (a == '0) begin
                d = '0;
                b = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = d;
        assign rd_busy[i]              = b;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard against an array-based reference model,
// plus directed scenarios for reset, collisions, scoreboard, flush and bypass.
module tb_regfile_scoreboard;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_rd;
    logic                 iss_ok;
    logic                 flush;
    logic [AW:0]          busy_cnt;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_rd(iss_rd), .iss_ok(iss_ok), .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mreg [NREGS];
    bit   [31:0] mbusy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic iss_acc();
        return iss_en && (iss_rd == 0 || !mbusy[iss_rd]) && !flush;
    endfunction

    function automatic logic [31:0] exp_rd(input int a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        for (int p = NWR - 1; p >= 0; p--)
            if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) return wr_data[p*XLEN +: XLEN];
`endif
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) return iss_acc() && int'(iss_rd) == a;
`endif
        return mbusy[a];
    endfunction

    task automatic idle();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = a[AW-1:0];
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    // Entered just after a falling edge with inputs set; leaves just after the next one.
    task automatic cyc();
        logic [31:0] nreg [NREGS];
        bit   [31:0] nbusy;
        logic        acc;
        #1;
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("rd_data%0d", i), rd_data[i*XLEN +: XLEN], exp_rd(int'(rd_addr[i*AW +: AW])));
            chk($sformatf("rd_busy%0d", i), rd_busy[i], exp_busy(int'(rd_addr[i*AW +: AW])));
        end
        chk("iss_ok", iss_ok, iss_acc());
        chk("busy_cnt", busy_cnt, $countones(mbusy));
        acc   = iss_acc();
        nreg  = mreg;
        nbusy = mbusy;
        for (int p = 0; p < NWR; p++) begin
            int a = int'(wr_addr[p*AW +: AW]);
            if (wr_en[p] && a != 0) begin
                nreg[a]  = wr_data[p*XLEN +: XLEN];
                nbusy[a] = 1'b0;
            end
        end
        if (acc && iss_rd != 0) nbusy[iss_rd] = 1'b1;
        if (flush) nbusy = '0;
        @(posedge clk);
        mreg  = nreg;
        mbusy = nbusy;
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) mreg[r] = 32'h0;
        mbusy = '0;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_cnt", busy_cnt, 0);
        @(negedge clk);

        // Basic write and x0 discard.
        set_wr(0, 5, 32'hDEADBEEF); cyc();
        idle(); rd_addr[0 +: AW] = 5; #1 chk("x5", rd_data[31:0], 32'hDEADBEEF); cyc();
        idle(); set_wr(0, 0, 32'h1234); cyc();
        idle(); rd_addr[0 +: AW] = 0; #1 chk("x0", rd_data[31:0], 32'h0); cyc();

        // Same-address collision: port1 wins.
        idle(); set_wr(0, 7, 32'h1); set_wr(1, 7, 32'h2); cyc();
        idle(); rd_addr[AW +: AW] = 7; #1 chk("x7", rd_data[XLEN +: XLEN], 32'h2); cyc();

        // Scoreboard claim, reject, release.
        idle(); iss_en = 1'b1; iss_rd = 3; cyc();
        idle(); rd_addr[0 +: AW] = 3; #1 chk("x3_busy", rd_busy[0], 1'b1);
        chk("cnt1", busy_cnt, 1);
        iss_en = 1'b1; iss_rd = 3; #1 chk("reissue", iss_ok, 1'b0); cyc();
        idle(); set_wr(0, 3, 32'h33); cyc();
        idle(); rd_addr[0 +: AW] = 3; #1 chk("x3_free", rd_busy[0], 1'b0);
        chk("cnt0", busy_cnt, 0); cyc();
        idle(); iss_en = 1'b1; iss_rd = 3; set_wr(1, 3, 32'h44); cyc();
        idle(); rd_addr[0 +: AW] = 3; #1 chk("x3_iss_wins", rd_busy[0], 1'b1); cyc();
        idle(); set_wr(0, 3, 32'h55); cyc();

        // Flush with concurrent issue and write.
        foreach (mbusy[k]) if (k == 1 || k == 2 || k == 4) begin
            idle(); iss_en = 1'b1; iss_rd = k[AW-1:0]; cyc();
        end
        idle(); #1 chk("cnt3", busy_cnt, 3);
        flush = 1'b1; iss_en = 1'b1; iss_rd = 6; set_wr(0, 9, 32'h8); cyc();
        idle(); rd_addr[0 +: AW] = 6; rd_addr[AW +: AW] = 9;
        #1 chk("flush_cnt", busy_cnt, 0);
        chk("x6_free", rd_busy[0], 1'b0);
        chk("x9", rd_data[XLEN +: XLEN], 32'h8); cyc();

        // Bypass visibility.
        idle(); set_wr(0, 10, 32'h1111); cyc();
        idle(); set_wr(0, 10, 32'hA5A5); rd_addr[0 +: AW] = 10;
`ifdef REGFILE_BYPASS_EN
        #1 chk("byp_same", rd_data[31:0], 32'hA5A5);
`else
        #1 chk("byp_same", rd_data[31:0], 32'h1111);
`endif
        cyc();
        idle(); rd_addr[0 +: AW] = 10; #1 chk("byp_next", rd_data[31:0], 32'hA5A5); cyc();

        // Random traffic on a narrow address window so hazards are frequent.
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 11));
            for (int p = 0; p < NWR; p++)
                if ($urandom_range(0, 2) == 0) set_wr(p, $urandom_range(0, 11), $urandom());
            iss_en = ($urandom_range(0, 1) == 0);
            iss_rd = AW'($urandom_range(0, 11));
            flush  = ($urandom_range(0, 19) == 0);
            cyc();
        end

        // Asynchronous reset mid-run.
        idle();
        for (int r = 1; r < 8; r++) begin iss_en = 1'b1; iss_rd = AW'(r); set_wr(0, r + 8, 32'hF0 + r); cyc(); end
        idle(); #2;
        rst_n = 1'b0;
        model_reset();
        for (int a = 0; a < 16; a += 2) begin
            rd_addr[0 +: AW] = AW'(a); rd_addr[AW +: AW] = AW'(a + 1);
            #1 chk("rst_rd0", rd_data[31:0], 32'h0);
            chk("rst_rd1", rd_data[XLEN +: XLEN], 32'h0);
            chk("rst_busy", rd_busy, 2'b00);
        end
        chk("rst_cnt_mid", busy_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
